// File: rtl/rsa_rng_pkg.sv
// ---------------------------------------------------------------------------
// rsa_rng_pkg
// Shared definitions for the RSA key-generation random source:
//   - default Galois feedback mask and reset/zero-substitute seed
//   - FSM state encoding for the word collector
//   - lfsr_next(): one Galois LFSR step on a vector of up to LFSR_MAX_W bits
// ---------------------------------------------------------------------------
package rsa_rng_pkg;

    // Widest LFSR the shared step function supports; narrower states are
    // zero-extended in and truncated out, which is exact for a right-shift LFSR.
    localparam int LFSR_MAX_W = 64;

    // x^32 + x^12 + x^11 + x^7 + x^2 + x + 1
    localparam logic [31:0] DEF_TAPS = 32'h8000_0C43;
    localparam logic [31:0] DEF_SEED = 32'hD4A5_6AAD;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rng_state_t;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// ---------------------------------------------------------------------------
// lfsr_galois
// Free-running Galois LFSR state register.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (state <= SEED)
//   en         in   advance the LFSR one step
//   seed_load  in   load seed_in (priority over en)
//   seed_in    in   WIDTH seed; zero is replaced by SEED
//   state      out  WIDTH current LFSR state
// ---------------------------------------------------------------------------
module lfsr_galois
    import rsa_rng_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] load_val;

    assign stepped  = WIDTH'(lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));
    // An all-zero state is a fixed point of the LFSR, so a zero seed is
    // swapped for the nonzero default instead.
    assign load_val = (seed_in == '0) ? SEED : seed_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (seed_load) begin
            state <= load_val;
        end else if (en) begin
            state <= stepped;
        end
    end

endmodule

// File: rtl/lfsr_rng_gen.sv
// ---------------------------------------------------------------------------
// lfsr_rng_gen
// Random prime-candidate source. A free-running Galois LFSR is sampled when
// start is accepted; OUT_WORDS successive LFSR states are concatenated (first
// capture in the most significant word) into rnd_out, optionally with the
// MSB and LSB forced to 1 so the word is an odd, full-length candidate.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          LFSR advance enable (also gates captures)
//   seed_load   load seed_in into the LFSR (stalls capture that cycle)
//   seed_in     WIDTH seed value (zero -> SEED)
//   start       request a new word, honoured only in IDLE
//   busy        high while collecting
//   done        one-cycle pulse when rnd_out is updated
//   rnd_valid   rnd_out holds a finished word; cleared by an accepted start
//   rnd_out     WIDTH*OUT_WORDS result, stable between done pulses
//   lfsr_state  current LFSR state
// ---------------------------------------------------------------------------
module lfsr_rng_gen
    import rsa_rng_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] TAPS          = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED          = WIDTH'(DEF_SEED),
    parameter int               OUT_WORDS     = 2,
    parameter bit               FORCE_ODD_TOP = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       seed_load,
    input  logic [WIDTH-1:0]           seed_in,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rnd_valid,
    output logic [WIDTH*OUT_WORDS-1:0] rnd_out,
    output logic [WIDTH-1:0]           lfsr_state
);

    localparam int TOT_W = WIDTH * OUT_WORDS;
    localparam int CNT_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_WORDS - 1);

    rng_state_t       fsm;
    logic [CNT_W-1:0] cnt;
    logic [TOT_W-1:0] acc;
    logic [TOT_W-1:0] acc_next;
    logic             capture;

    function automatic logic [TOT_W-1:0] force_odd(input logic [TOT_W-1:0] w);
        logic [TOT_W-1:0] r;
        r = w;
        if (FORCE_ODD_TOP) begin
            r[TOT_W-1] = 1'b1;
            r[0]       = 1'b1;
        end
        return r;
    endfunction

    lfsr_galois #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .state     (lfsr_state)
    );

    // Shift the pre-edge LFSR state in at the bottom; the oldest capture
    // drifts up into the most significant word. Truncation keeps the low
    // TOT_W bits, which also covers OUT_WORDS == 1.
    assign acc_next = TOT_W'({acc, lfsr_state});
    assign capture  = (fsm == COLLECT) && en && !seed_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rnd_valid <= 1'b0;
            rnd_out   <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        fsm       <= COLLECT;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        rnd_valid <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (capture) begin
                        acc <= acc_next;
                        if (cnt == LAST) begin
                            rnd_out   <= force_odd(acc_next);
                            done      <= 1'b1;
                            rnd_valid <= 1'b1;
                            busy      <= 1'b0;
                            fsm       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rng_gen
// Bench for lfsr_rng_gen: two instances (forcing on / off) share stimulus and
// are compared every cycle against a transaction-level model; directed
// sequences pin the model with literal vectors, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_lfsr_rng_gen;

    localparam int          W    = 32;
    localparam int          OW   = 2;
    localparam int          TOT  = W * OW;
    localparam logic [31:0] TAPS = 32'h8000_0C43;
    localparam logic [31:0] SEED = 32'hD4A5_6AAD;
    localparam logic [63:0] FORCE_MASK = 64'h8000_0000_0000_0001;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           seed_load;
    logic [W-1:0]   seed_in;
    logic           start;
    logic           busy, done, rnd_valid;
    logic [TOT-1:0] rnd_out;
    logic [W-1:0]   lfsr_state;
    logic           busy2, done2, rnd_valid2;
    logic [TOT-1:0] rnd_out2;
    logic [W-1:0]   lfsr_state2;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    lfsr_rng_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rnd_valid  (rnd_valid),
        .rnd_out    (rnd_out),
        .lfsr_state (lfsr_state)
    );

    lfsr_rng_gen #(.FORCE_ODD_TOP(1'b0)) dut_raw (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .start      (start),
        .busy       (busy2),
        .done       (done2),
        .rnd_valid  (rnd_valid2),
        .rnd_out    (rnd_out2),
        .lfsr_state (lfsr_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Halving plus conditional XOR of the mask: the Galois rule in arithmetic form.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        return (s / 2) ^ ((s % 2 == 1) ? TAPS : 32'h0);
    endfunction

    logic [31:0] m_state;
    logic [31:0] m_pre;
    bit          m_busy, m_done, m_valid;
    logic [63:0] m_raw, m_out;
    logic [31:0] m_q[$];

    initial begin
        m_state = SEED; m_busy = 0; m_done = 0; m_valid = 0; m_raw = 0; m_out = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = SEED; m_busy = 0; m_done = 0; m_valid = 0;
                m_raw = 0; m_out = 0; m_q.delete();
            end else begin
                m_pre  = m_state;
                m_done = 0;
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1; m_valid = 0; m_q.delete();
                    end
                end else if (en && !seed_load) begin
                    m_q.push_back(m_pre);
                    if (m_q.size() == OW) begin
                        m_raw = 0;
                        for (int i = 0; i < OW; i++) m_raw = (m_raw << W) | 64'(m_q[i]);
                        m_out   = m_raw | FORCE_MASK;
                        m_done  = 1; m_valid = 1; m_busy = 0;
                    end
                end
                if (seed_load)  m_state = (seed_in == 0) ? SEED : seed_in;
                else if (en)    m_state = m_step(m_state);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("lfsr_state", 64'(lfsr_state), 64'(m_state));
                chk("busy",       64'(busy),       64'(m_busy));
                chk("done",       64'(done),       64'(m_done));
                chk("rnd_valid",  64'(rnd_valid),  64'(m_valid));
                chk("rnd_out",    rnd_out,         m_out);
                chk("raw_state",  64'(lfsr_state2), 64'(m_state));
                chk("raw_done",   64'(done2),      64'(m_done));
                chk("raw_busy",   64'(busy2),      64'(m_busy));
                chk("raw_valid",  64'(rnd_valid2), 64'(m_valid));
                chk("raw_rnd_out", rnd_out2,       m_raw);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_seed(input logic [31:0] v);
        seed_load = 1; seed_in = v;
        @(negedge clk);
        seed_load = 0;
    endtask

    // Pulse start, then wait (bounded) for done. During the first 'stall'
    // cycles of collection en is low and start is held high.
    task automatic do_start(input int stall, output int lat, output int bcnt);
        bit seen;
        start = 1;
        @(negedge clk);
        start = 0; lat = 0; bcnt = 0; seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (busy) bcnt++;
            if (done) seen = 1;
            else begin
                en    = (lat < stall) ? 1'b0 : 1'b1;
                start = (lat < stall) ? 1'b1 : 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        en = 1; start = 0;
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    int lat, bcnt, ndone;

    initial begin
        rst_n = 0; en = 0; seed_load = 0; seed_in = 0; start = 0;
        repeat (2) @(negedge clk);
        chk_on = 1;
        // reset state
        chk("rst_state", 64'(lfsr_state), 64'hD4A5_6AAD);
        chk("rst_out",   rnd_out, 64'h0);
        chk("rst_flags", {61'b0, busy, done, rnd_valid}, 64'h0);

        // test 1: free run
        rst_n = 1; en = 1;
        @(negedge clk);
        chk("t1_S1", 64'(lfsr_state), 64'hEA52_B915);
        @(negedge clk);
        chk("t1_S2", 64'(lfsr_state), 64'hF529_50C9);
        chk("t1_out", rnd_out, 64'h0);

        // test 2
        load_seed(32'hD4A5_6AAD);
        do_start(0, lat, bcnt);
        chk("t2_out",   rnd_out, 64'hEA52_B915_F529_50C9);
        chk("t2_valid", 64'(rnd_valid), 64'd1);
        chk("t2_lat",   64'(lat), 64'd2);
        chk("t2_busy",  64'(bcnt), 64'd2);

        // test 3
        load_seed(32'h0000_0002);
        do_start(0, lat, bcnt);
        chk("t3_forced", rnd_out,  64'h8000_0001_8000_0C43);
        chk("t3_raw",    rnd_out2, 64'h0000_0001_8000_0C43);

        // test 4: zero seed substitution
        load_seed(32'h0);
        chk("t4_state", 64'(lfsr_state), 64'hD4A5_6AAD);
        do_start(0, lat, bcnt);
        chk("t4_out", rnd_out, 64'hEA52_B915_F529_50C9);

        // test 5: stall en for 3 cycles with start pulses while busy
        load_seed(32'hD4A5_6AAD);
        do_start(3, lat, bcnt);
        chk("t5_out",  rnd_out, 64'hEA52_B915_F529_50C9);
        chk("t5_lat",  64'(lat), 64'd5);
        chk("t5_busy", 64'(bcnt), 64'd5);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_extra_done", 64'(ndone), 64'd0);

        // test 6: asynchronous reset mid-collect
        load_seed(32'hD4A5_6AAD);
        start = 1;
        @(negedge clk);
        start = 0;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("t6_state", 64'(lfsr_state), 64'hD4A5_6AAD);
        chk("t6_out",   rnd_out, 64'h0);
        chk("t6_flags", {61'b0, busy, done, rnd_valid}, 64'h0);
        @(negedge clk);
        rst_n = 1;
        do_start(0, lat, bcnt);
        chk("t6_out2", rnd_out, 64'hEA52_B915_F529_50C9);

        // random traffic, checked by the per-cycle compare
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) < 8);
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            start     = ($urandom_range(0, 9) < 3);
            @(negedge clk);
        end
        en = 1; seed_load = 0; start = 0;
        repeat (4) @(negedge clk);

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
